// File: rtl/seqdet_capture.sv
// Serial-frame capture: assembles an N-bit LSB-first frame from x, records the per-bit
// hit mask and hit count from z, and holds the result until the next start.
module seqdet_capture #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         bit_en,
    input  logic         x,
    input  logic         z,
    output logic [N-1:0] data,
    output logic [N-1:0] hit_mask,
    output logic [3:0]   hit_cnt,
    output logic [3:0]   bit_idx,
    output logic         busy,
    output logic         done,
    output logic         done_pulse
);

    typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] data_q, data_d;
    logic [N-1:0] mask_q, mask_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   idx_q, idx_d;
    logic         pulse_q, pulse_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            data_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pulse_d = 1'b0;

        if (start) begin
            // start wins over a coincident bit_en in every state
            state_d = StCapture;
            data_d  = '0;
            mask_d  = '0;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StCapture: begin
                    if (bit_en) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            if (idx_q == 4'(i)) begin
                                data_d[i] = x;
                                mask_d[i] = z;
                            end
                        end
                        cnt_d = cnt_q + {3'b000, z};
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'(N - 1)) begin
                            state_d = StDone;
                            pulse_d = 1'b1;
                        end
                    end
                end
                StIdle, StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    assign data       = data_q;
    assign hit_mask   = mask_q;
    assign hit_cnt    = cnt_q;
    assign bit_idx    = idx_q;
    assign busy       = (state_q == StCapture);
    assign done       = (state_q == StDone);
    assign done_pulse = pulse_q;

endmodule

// File: tb/tb_seqdet_capture.sv
// Bench for seqdet_capture: directed scenarios, a vector table and a randomized run
// against a queue-based frame model.
module tb_seqdet_capture;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         bit_en = 1'b0;
    logic         x = 1'b0;
    logic         z = 1'b0;
    logic [N-1:0] data;
    logic [N-1:0] hit_mask;
    logic [3:0]   hit_cnt;
    logic [3:0]   bit_idx;
    logic         busy;
    logic         done;
    logic         done_pulse;

    int checks = 0;
    int errors = 0;

    seqdet_capture #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bit_en     (bit_en),
        .x          (x),
        .z          (z),
        .data       (data),
        .hit_mask   (hit_mask),
        .hit_cnt    (hit_cnt),
        .bit_idx    (bit_idx),
        .busy       (busy),
        .done       (done),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: the frame is just the list of (x, z) bits received so far.
    bit q_x[$];
    bit q_z[$];
    bit m_cap, m_done, m_pulse;

    int cyc = 0, busy_rise = -1, done_rise = -1, pulse_cnt = 0;
    logic prev_busy = 1'b0, prev_done = 1'b0;

    function automatic logic [N-1:0] m_data();
        logic [N-1:0] v = '0;
        foreach (q_x[i]) v = v | (N'(q_x[i]) << i);
        return v;
    endfunction

    function automatic logic [N-1:0] m_mask();
        logic [N-1:0] v = '0;
        foreach (q_z[i]) v = v | (N'(q_z[i]) << i);
        return v;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        foreach (q_z[i]) c += int'(q_z[i]);
        return c;
    endfunction

    task automatic model_clear();
        q_x.delete();
        q_z.delete();
        m_cap = 0;
        m_done = 0;
        m_pulse = 0;
    endtask

    task automatic model_step();
        m_pulse = 0;
        if (!reset) begin
            model_clear();
        end else if (start) begin
            q_x.delete();
            q_z.delete();
            m_cap = 1;
            m_done = 0;
        end else if (m_cap && bit_en) begin
            q_x.push_back(x);
            q_z.push_back(z);
            if (q_x.size() == N) begin
                m_cap = 0;
                m_done = 1;
                m_pulse = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".data"}, 32'(data), 32'(m_data()));
        chk({tag, ".mask"}, 32'(hit_mask), 32'(m_mask()));
        chk({tag, ".cnt"}, 32'(hit_cnt), 32'(m_cnt()));
        chk({tag, ".idx"}, 32'(bit_idx), 32'(q_x.size()));
        chk({tag, ".busy"}, 32'(busy), 32'(m_cap));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".pulse"}, 32'(done_pulse), 32'(m_pulse));
    endtask

    task automatic set_in(input logic s, input logic b, input logic xi, input logic zi);
        start = s;
        bit_en = b;
        x = xi;
        z = zi;
    endtask

    // One clock: update the model with the inputs the DUT sampled, then compare 1 ns later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        if (busy && !prev_busy) busy_rise = cyc;
        if (done && !prev_done) done_rise = cyc;
        if (done_pulse === 1'b1) pulse_cnt++;
        prev_busy = busy;
        prev_done = done;
        compare_model(tag);
    endtask

    typedef struct {
        logic       s, b, xi, zi;
        logic [7:0] e_data, e_mask;
        logic [3:0] e_cnt, e_idx;
        logic       e_busy, e_done, e_pulse;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [7:0] fx;
        logic [7:0] fz;
        model_clear();

        // Back-to-back strobes, x=1 z=1, starting from DONE
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 8'h03, 4'd2, 4'd2, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 8'h07, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h0F, 8'h0F, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h1F, 8'h1F, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h3F, 8'h3F, 4'd6, 4'd6, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h7F, 8'h7F, 4'd7, 4'd7, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 4'd8, 4'd8, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 4'd8, 4'd8, 1'b0, 1'b1, 1'b0};

        // 1. Reset held with random inputs, then released with start low
        for (int i = 0; i < 4; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            cycle("rst_hold");
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) cycle("rst_release");

        // 6a. Strobes in IDLE are ignored
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 1'b1, 1'b1);
            cycle("idle_strobe");
        end
        chk("idle_data", 32'(data), 32'h0);

        // 2. Basic frame with idle gaps
        fx = 8'hB6;
        fz = 8'h48;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        cycle("basic_start");
        pulse_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 1'b1, fx[i], fz[i]);
            cycle("basic_bit");
            set_in(1'b0, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) cycle("basic_gap");
        end
        chk("basic_data", 32'(data), 32'hB6);
        chk("basic_mask", 32'(hit_mask), 32'h48);
        chk("basic_cnt", 32'(hit_cnt), 32'd2);
        chk("basic_idx", 32'(bit_idx), 32'd8);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_busy", 32'(busy), 32'd0);
        chk("basic_pulses", 32'(pulse_cnt), 32'd1);

        // 6b. Strobes in DONE are ignored
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1, 1'($urandom), 1'($urandom));
            cycle("done_strobe");
        end
        chk("done_hold_data", 32'(data), 32'hB6);
        chk("done_hold_cnt", 32'(hit_cnt), 32'd2);

        // 3. Table-driven back-to-back frame
        busy_rise = -1;
        done_rise = -1;
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].s, tbl[i].b, tbl[i].xi, tbl[i].zi);
            cycle("tbl");
            chk($sformatf("tbl%0d.data", i), 32'(data), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d.mask", i), 32'(hit_mask), 32'(tbl[i].e_mask));
            chk($sformatf("tbl%0d.cnt", i), 32'(hit_cnt), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.idx", i), 32'(bit_idx), 32'(tbl[i].e_idx));
            chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d.done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d.pulse", i), 32'(done_pulse), 32'(tbl[i].e_pulse));
        end
        chk("b2b_latency", 32'(done_rise - busy_rise), 32'd8);

        // 4. Restart mid-frame
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        cycle("rs_start");
        pulse_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1, 1'b1, 1'($urandom));
            cycle("rs_bit");
        end
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        cycle("rs_restart");
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("rs_no_early_pulse", 32'(pulse_cnt), 32'd0);
            set_in(1'b0, 1'b1, 1'b0, 1'b0);
            cycle("rs_bit2");
        end
        chk("rs_data", 32'(data), 32'h0);
        chk("rs_cnt", 32'(hit_cnt), 32'd0);
        chk("rs_pulses", 32'(pulse_cnt), 32'd1);

        // 5. Asynchronous reset mid-frame, then a fresh frame
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        cycle("mr_start");
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b1, 1'b1, 1'b1);
            cycle("mr_bit");
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        compare_model("mr_async");
        cycle("mr_held");
        reset = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        cycle("mr_start2");
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 1'b1, 1'($urandom), 1'($urandom));
            cycle("mr_bit2");
        end

        // Randomized run with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
            if (reset && $urandom_range(0, 79) == 0) begin
                reset = 1'b0;
                model_clear();
            end else if (!reset) begin
                reset = 1'b1;
            end
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seqdet_capture.md
# seqdet_capture

Serial-frame capture block: the receiving end of the bit-serial stream that feeds the sequence detector. It samples one serial bit `x` and the detector output `z` on each bit strobe and assembles an N-bit frame, with the LSB first. It also records a per-bit hit mask and a hit count, then holds the results for display on the LEDs and seven-segment digits. It sits beside `seqdet` in the lab top level, on the divided bit clock enable.

## Interface
- `N`, default 8: frame length in bits; legal range 2–15.
- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately. Release is synchronous to `clk` externally.
- `start` input 1: single-cycle request to begin a new frame.
- `bit_en` input 1: bit strobe, high for one `clk` cycle per bit period.
- `x` input 1: serial data bit; valid when `bit_en`=1.
- `z` input 1: detector output for the same bit; valid when `bit_en`=1.
- `data` output N: captured frame; the first bit received is in `data[0]`.
- `hit_mask` output N: `hit_mask[i]`=1 when `z` was 1 on bit i.
- `hit_cnt` output 4: number of bits with `z`=1, from 0 to N.
- `bit_idx` output 4: index of the next bit to capture, from 0 to N.
- `busy` output 1: high in CAPTURE.
- `done` output 1: high in DONE; held until the next `start` or reset.
- `done_pulse` output 1: high for exactly one cycle on entry to DONE.

## Operation
- States are IDLE, CAPTURE and DONE. After reset the block is in IDLE.
- Reset values: `data`=0, `hit_mask`=0, `hit_cnt`=0, `bit_idx`=0, `busy`=0, `done`=0, `done_pulse`=0.
- In IDLE or DONE, `start`=1 triggers a clear:
  - `data`, `hit_mask`, `hit_cnt` and `bit_idx` are set to 0.
  - The next state is CAPTURE.
  - A `bit_en` in the same cycle as `start` is ignored.
- In CAPTURE, `bit_en`=1 with `start`=0 performs a bit capture:
  - `data[bit_idx]` ← `x`
  - `hit_mask[bit_idx]` ← `z`
  - `hit_cnt` ← `hit_cnt` + `z`
  - `bit_idx` ← `bit_idx` + 1
- When that capture has `bit_idx`=N−1:
  - `bit_idx` becomes N and the next state is DONE.
  - `done_pulse` is asserted for the following cycle only.
- `start` during CAPTURE restarts the frame: the same clear as above is applied and the block stays in CAPTURE. Partial results are discarded and `done_pulse` is not generated.
- `bit_en` in IDLE or DONE is ignored; all outputs hold.
- Outputs hold their values in DONE.
- `hit_cnt` never exceeds N and does not wrap. `bit_idx` never exceeds N.
- Reset asserted mid-frame returns to IDLE with all outputs at their reset values. No partial frame is retained.
- Holding `start` high continuously clears the frame every cycle and stays in CAPTURE, so no bits are captured.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Capture latency is one cycle: the bit captured on the edge where `bit_en`=1 is visible on `data` and `hit_mask` after that edge.
- `busy` rises on the edge after `start`. `busy` falls, and `done` and `done_pulse` rise, on the same edge that captures bit N−1.
- `done_pulse` falls one cycle later; `done` stays high.
- Minimum frame time is 1 cycle for `start` plus N cycles with `bit_en` back-to-back. `bit_en` may be asserted on every cycle.
- `reset` acts asynchronously on assertion. No input has an effect while `reset`=0.

## Test plan
1. **Reset:** drive random inputs with `reset`=0. Then release reset with `start`=0 for 5 cycles. Required: all outputs stay 0 and the block remains in IDLE.
2. **Basic frame:** use N=8. Pulse `start`, then apply 8 `bit_en` strobes, 3 idle cycles apart, with `x` = 0,1,1,0,1,1,0,1 and `z` = 0,0,0,1,0,0,1,0. Required:
   - `data`=8'hB6, `hit_mask`=8'h48, `hit_cnt`=2, `bit_idx`=8.
   - `done_pulse` is high for exactly one cycle; `done` remains high and `busy`=0.
3. **Back-to-back strobes:** `bit_en` held high for 8 cycles right after `start`, with `x`=1 and `z`=1 on every bit. Required:
   - `data`=8'hFF, `hit_mask`=8'hFF, `hit_cnt`=8.
   - `done` rises exactly 8 cycles after `busy` rises.
4. **Restart mid-frame:** after 4 bits with `x`=1, pulse `start` together with `bit_en`. Then feed 8 bits with `x`=0 and `z`=0. Required:
   - `data`=0, `hit_cnt`=0.
   - No `done_pulse` between the first `start` and the completion of the second frame.
5. **Reset mid-frame:** assert `reset` after 5 bits, asynchronously between clock edges. Required: all outputs read 0 immediately, before the next edge. After release, a new frame captures correctly.
6. **Ignored strobes:** issue `bit_en` pulses in IDLE and then in DONE after scenario 2. Required: no output changes, and `data` stays 8'hB6 in DONE.
